// File: rtl/nes_pkg.sv
// Shared definitions for the iNES/NROM image loader.
//   loader_state_t : loader FSM states
//   loader_err_t   : error codes reported on the loader error port
//   INES_MAGIC, INES_HDR_LEN, TRAINER_LEN, PRG_BANK_BYTES, CHR_BANK_BYTES
//   magic_byte()   : byte n (0..3) of the iNES magic, in stream order
package nes_pkg;

  typedef enum logic [2:0] {
    ST_HDR     = 3'd0,
    ST_TRAINER = 3'd1,
    ST_PRG     = 3'd2,
    ST_CHR     = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } loader_state_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_MAGIC    = 3'd1,
    ERR_PRG_SIZE = 3'd2,
    ERR_CHR_SIZE = 3'd3,
    ERR_MAPPER   = 3'd4
  } loader_err_t;

  localparam logic [31:0] INES_MAGIC     = 32'h4E45_531A;
  localparam int          INES_HDR_LEN   = 16;
  localparam int          TRAINER_LEN    = 512;
  localparam int          PRG_BANK_BYTES = 16384;
  localparam int          CHR_BANK_BYTES = 8192;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = INES_MAGIC[31:24];
      2'd1:    b = INES_MAGIC[23:16];
      2'd2:    b = INES_MAGIC[15:8];
      default: b = INES_MAGIC[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ines_rom_loader.sv
// iNES (NROM / mapper 0) byte-stream loader feeding the cartridge programmer.
// Parses and validates the 16-byte header, drops an optional 512-byte trainer,
// then writes PRG bytes on the programmer port and CHR bytes on the CHR strobe.
// The CPU is held in reset until the whole image has been written.
//
// Ports:
//   CLK, RESET_n   clock, asynchronous active-low reset
//   restart        synchronous abort; back to header parsing
//   byte_valid     upstream byte present
//   byte_data[7:0] upstream image byte
//   byte_ready     byte accepted this cycle (combinational)
//   prgmr_wren     one-cycle PRG write strobe
//   chr_wren       one-cycle CHR write strobe
//   prgmr_addr     byte offset within the region being written
//   prgmr_data     write data
//   cpu_hold       keep CPU in reset
//   done           image loaded
//   error[2:0]     loader_err_t code
//   prg_banks[1:0] 16 KB PRG bank count from the header
//   mirroring      header flags6 bit 0
module ines_rom_loader
  import nes_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        restart,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        prgmr_wren,
  output logic        chr_wren,
  output logic [15:0] prgmr_addr,
  output logic [7:0]  prgmr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic [2:0]  error,
  output logic [1:0]  prg_banks,
  output logic        mirroring
);

  loader_state_t state, state_next;
  loader_err_t   err_q, err_next, hdr_err;

  logic [3:0]  hdr_idx;
  logic [8:0]  trn_cnt;
  logic [14:0] prg_off;
  logic [12:0] chr_cnt;
  logic        chr_bank;
  logic        trainer;
  logic [3:0]  mapper_lo;
  logic        accept;
  logic        prg_last;

  assign error = err_q;

  // Last PRG byte: 0x3FFF for one bank, 0x7FFF for two.
  assign prg_last = (&prg_off[13:0]) & (prg_off[14] | (prg_banks != 2'd2));

  // Validation of the header byte currently presented at hdr_idx.
  always_comb begin
    hdr_err = ERR_NONE;
    case (hdr_idx)
      4'd0, 4'd1, 4'd2, 4'd3:
        if (byte_data != magic_byte(hdr_idx[1:0])) hdr_err = ERR_MAGIC;
      4'd4:
        if ((byte_data != 8'd1) && (byte_data != 8'd2)) hdr_err = ERR_PRG_SIZE;
      4'd5:
        if (byte_data > 8'd1) hdr_err = ERR_CHR_SIZE;
      4'd7:
        if ({byte_data[7:4], mapper_lo} != 8'd0) hdr_err = ERR_MAPPER;
      default: hdr_err = ERR_NONE;
    endcase
  end

  // ---- state register ----
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state <= ST_HDR;
      err_q <= ERR_NONE;
    end else begin
      state <= state_next;
      err_q <= err_next;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_next = state;
    err_next   = err_q;
    if (restart) begin
      state_next = ST_HDR;
      err_next   = ERR_NONE;
    end else begin
      case (state)
        ST_HDR:
          if (accept) begin
            if (hdr_err != ERR_NONE) begin
              state_next = ST_ERR;
              err_next   = hdr_err;
            end else if (hdr_idx == 4'(INES_HDR_LEN - 1)) begin
              state_next = trainer ? ST_TRAINER : ST_PRG;
            end
          end
        ST_TRAINER:
          if (accept && (trn_cnt == 9'(TRAINER_LEN - 1))) state_next = ST_PRG;
        ST_PRG:
          if (accept && prg_last) state_next = chr_bank ? ST_CHR : ST_DONE;
        ST_CHR:
          if (accept && (chr_cnt == 13'(CHR_BANK_BYTES - 1))) state_next = ST_DONE;
        default: state_next = state;
      endcase
    end
  end

  // ---- output logic ----
  always_comb begin
    byte_ready = ((state == ST_HDR) || (state == ST_TRAINER) ||
                  (state == ST_PRG) || (state == ST_CHR)) && !restart;
    accept     = byte_valid && byte_ready;
  end

  // ---- counters, header latches, registered write port ----
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      hdr_idx    <= '0;
      trn_cnt    <= '0;
      prg_off    <= '0;
      chr_cnt    <= '0;
      chr_bank   <= 1'b0;
      trainer    <= 1'b0;
      mapper_lo  <= '0;
      prg_banks  <= '0;
      mirroring  <= 1'b0;
      prgmr_wren <= 1'b0;
      chr_wren   <= 1'b0;
      prgmr_addr <= '0;
      prgmr_data <= '0;
      done       <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      prgmr_wren <= 1'b0;
      chr_wren   <= 1'b0;
      // done follows the DONE state by one cycle, i.e. one cycle after the last strobe
      done       <= (state == ST_DONE) && !restart;
      cpu_hold   <= (state != ST_DONE) || restart;
      if (restart) begin
        hdr_idx <= '0;
        trn_cnt <= '0;
        prg_off <= '0;
        chr_cnt <= '0;
      end else if (accept) begin
        case (state)
          ST_HDR: begin
            hdr_idx <= hdr_idx + 4'd1;
            case (hdr_idx)
              4'd4: prg_banks <= byte_data[1:0];
              4'd5: chr_bank  <= byte_data[0];
              4'd6: begin
                mirroring <= byte_data[0];
                trainer   <= byte_data[2];
                mapper_lo <= byte_data[7:4];
              end
              default: ;
            endcase
          end
          ST_TRAINER: trn_cnt <= trn_cnt + 9'd1;
          ST_PRG: begin
            prgmr_wren <= 1'b1;
            prgmr_addr <= {1'b0, prg_off};
            prgmr_data <= byte_data;
            prg_off    <= prg_off + 15'd1;
          end
          ST_CHR: begin
            chr_wren   <= 1'b1;
            prgmr_addr <= {3'b000, chr_cnt};
            prgmr_data <= byte_data;
            chr_cnt    <= chr_cnt + 13'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ines_rom_loader.sv
// Randomized self-checking bench for ines_rom_loader. Images are built with
// random contents; a queue-based reference model derives the expected write
// list, error code and number of consumed bytes straight from the iNES rules.
module tb_ines_rom_loader;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic        restart;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        prgmr_wren;
  logic        chr_wren;
  logic [15:0] prgmr_addr;
  logic [7:0]  prgmr_data;
  logic        cpu_hold;
  logic        done;
  logic [2:0]  error;
  logic [1:0]  prg_banks;
  logic        mirroring;

  always #5 CLK = ~CLK;

  ines_rom_loader dut (
    .CLK        (CLK),
    .RESET_n    (RESET_n),
    .restart    (restart),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .prgmr_wren (prgmr_wren),
    .chr_wren   (chr_wren),
    .prgmr_addr (prgmr_addr),
    .prgmr_data (prgmr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .prg_banks  (prg_banks),
    .mirroring  (mirroring)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // image, expected writes {is_chr, addr, data}, observed writes
  logic [7:0]  img[$];
  logic [24:0] exp_q[$];
  logic [24:0] got_q[$];
  int          exp_err;
  int          exp_consumed;

  always @(negedge CLK) begin
    if (prgmr_wren) got_q.push_back({1'b0, prgmr_addr, prgmr_data});
    if (chr_wren)   got_q.push_back({1'b1, prgmr_addr, prgmr_data});
  end

  task automatic make_image(input logic [7:0] prg, input logic [7:0] chr,
                            input logic [7:0] f6, input logic [7:0] f7);
    int n_prg, n_chr;
    img.delete();
    img.push_back(8'h4E); img.push_back(8'h45);
    img.push_back(8'h53); img.push_back(8'h1A);
    img.push_back(prg);   img.push_back(chr);
    img.push_back(f6);    img.push_back(f7);
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    if (f6[2]) for (int i = 0; i < 512; i++) img.push_back(8'($urandom));
    n_prg = (prg == 8'd1 || prg == 8'd2) ? int'(prg) * 16384 : 64;
    n_chr = (chr == 8'd1) ? 8192 : 0;
    for (int i = 0; i < n_prg + n_chr; i++) img.push_back(8'($urandom));
  endtask

  // Reference model: straight from the iNES header rules.
  task automatic model();
    logic [7:0] magic[4];
    logic [7:0] b6, b7;
    int base, n;
    magic = '{8'h4E, 8'h45, 8'h53, 8'h1A};
    exp_q.delete();
    exp_err = 0;
    exp_consumed = img.size();
    for (int i = 0; i < 4; i++)
      if (img[i] != magic[i]) begin exp_err = 1; exp_consumed = i + 1; return; end
    if (img[4] != 8'd1 && img[4] != 8'd2) begin exp_err = 2; exp_consumed = 5; return; end
    if (img[5] > 8'd1) begin exp_err = 3; exp_consumed = 6; return; end
    b6 = img[6];
    b7 = img[7];
    if ((b7 & 8'hF0) != 8'd0 || (b6 & 8'hF0) != 8'd0) begin
      exp_err = 4; exp_consumed = 8; return;
    end
    base = 16 + (b6[2] ? 512 : 0);
    n = int'(img[4]) * 16384;
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 16'(i), img[base + i]});
    base += n;
    n = int'(img[5]) * 8192;
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 16'(i), img[base + i]});
  endtask

  // Feeds img[0..limit-1]; returns at a negedge: either the one right after the
  // last acceptance, or the first one where byte_ready was seen low.
  task automatic stream(input int pct, input int limit, output int consumed);
    int idx, cyc, budget;
    idx = 0; cyc = 0;
    budget = limit * 4 + 200;
    while (idx < limit) begin
      @(negedge CLK);
      byte_valid = 1'b0;
      if (!byte_ready) break;
      if (cyc > budget) begin
        chk("stream_timeout", idx, limit);
        break;
      end
      cyc++;
      byte_valid = ($urandom_range(99) < pct);
      byte_data  = img[idx];
      @(posedge CLK);
      if (byte_valid) idx++;
    end
    if (idx == limit) begin
      @(negedge CLK);
      byte_valid = 1'b0;
    end
    consumed = idx;
  endtask

  task automatic do_restart();
    @(negedge CLK);
    restart = 1'b1;
    @(negedge CLK);
    restart = 1'b0;
    #1;
    chk("rst_done", done, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_err", error, 0);
    chk("rst_ready", byte_ready, 1);
    got_q.delete();
  endtask

  task automatic cmp_writes(input string name, input int n);
    chk({name, "_wr_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      int f0;
      f0 = failures;
      chk($sformatf("%s_wr%0d", name, i), got_q[i], exp_q[i]);
      if (failures != f0) break;
    end
  endtask

  task automatic run_case(input string name, input int pct);
    int consumed, n_chr;
    do_restart();
    model();
    stream(pct, img.size(), consumed);
    chk({name, "_consumed"}, consumed, exp_consumed);
    if (exp_err != 0) begin
      chk({name, "_err"}, error, exp_err);
      chk({name, "_ready"}, byte_ready, 0);
      chk({name, "_hold"}, cpu_hold, 1);
      chk({name, "_done"}, done, 0);
      repeat (3) @(negedge CLK);
      chk({name, "_err_sticky"}, error, exp_err);
      chk({name, "_no_wr"}, got_q.size(), 0);
    end else begin
      chk({name, "_done_early"}, done, 0);
      chk({name, "_hold_early"}, cpu_hold, 1);
      @(negedge CLK);
      chk({name, "_done"}, done, 1);
      chk({name, "_hold"}, cpu_hold, 0);
      chk({name, "_ready"}, byte_ready, 0);
      chk({name, "_err"}, error, 0);
      chk({name, "_banks"}, prg_banks, img[4][1:0]);
      chk({name, "_mirr"}, mirroring, img[6][0]);
      n_chr = 0;
      foreach (got_q[i]) if (got_q[i][24]) n_chr++;
      chk({name, "_chr_count"}, n_chr, int'(img[5]) * 8192);
      cmp_writes(name, exp_q.size());
    end
  endtask

  initial begin
    int consumed, pre;
    RESET_n = 1'b0; restart = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    #12;
    chk("reset_hold", cpu_hold, 1);
    chk("reset_done", done, 0);
    chk("reset_err", error, 0);
    chk("reset_prg_wr", prgmr_wren, 0);
    chk("reset_chr_wr", chr_wren, 0);
    chk("reset_addr", prgmr_addr, 0);
    chk("reset_data", prgmr_data, 0);
    chk("reset_banks", prg_banks, 0);
    chk("reset_mirr", mirroring, 0);
    @(negedge CLK);
    RESET_n = 1'b1;
    #1;
    chk("reset_ready", byte_ready, 1);

    // NROM-256, back-to-back
    make_image(8'd2, 8'd1, 8'h01, 8'h00);
    run_case("nrom256", 100);

    // restart mid-PRG together with a valid byte, then full trainer image
    make_image(8'd1, 8'd0, 8'h04, 8'h00);
    do_restart();
    model();
    pre = 16 + 512 + 100;
    stream(100, pre, consumed);
    restart    = 1'b1;
    byte_valid = 1'b1;
    byte_data  = img[pre];
    @(posedge CLK);
    @(negedge CLK);
    chk("restart_no_wr", prgmr_wren, 0);
    restart    = 1'b0;
    byte_valid = 1'b0;
    #1;
    chk("restart_ready", byte_ready, 1);
    chk("restart_hold", cpu_hold, 1);
    cmp_writes("restart_prefix", 100);
    run_case("nrom128_trainer", 100);

    // random byte_valid gaps
    make_image(8'd1, 8'd0, 8'h01, 8'h00);
    run_case("nrom128_gaps", 80);

    // header errors
    make_image(8'd2, 8'd1, 8'h01, 8'h00);
    img[2] = 8'h54;
    run_case("bad_magic", 100);
    make_image(8'd3, 8'd0, 8'h00, 8'h00);
    run_case("bad_prg", 70);
    make_image(8'd1, 8'd2, 8'h00, 8'h00);
    run_case("bad_chr", 70);
    make_image(8'd1, 8'd0, 8'h10, 8'h00);
    run_case("mapper1", 100);
    make_image(8'd1, 8'd0, 8'h00, 8'h20);
    run_case("mapper_hi", 70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ines_rom_loader.md
# ines_rom_loader

Byte-stream loader sitting directly upstream of the cartridge's programmer port. It consumes a raw iNES image one byte at a time, parses and validates the 16-byte header, and skips an optional 512-byte trainer. It writes PRG-ROM bytes through the programmer write port and CHR-ROM bytes through a parallel CHR strobe, and holds the CPU in reset until the image is fully loaded. Scope is NROM (mapper 0) only.

## Interface
Parameters:
- none; all widths fixed by the iNES/NROM format.

Ports:
- CLK  in  1  system clock (same domain as the cartridge programmer port).
- RESET_n  in  1  asynchronous, active-low reset.
- restart  in  1  synchronous; aborts any load and returns to header parsing.
- byte_valid  in  1  upstream byte present.
- byte_data  in  8  upstream image byte.
- byte_ready  out  1  loader accepts `byte_data` this cycle; combinational.
- prgmr_wren  out  1  one-cycle PRG write strobe to the cartridge.
- chr_wren  out  1  one-cycle CHR write strobe.
- prgmr_addr  out  16  byte offset within the region being written (PRG 0x0000–0x7FFF, CHR 0x0000–0x1FFF).
- prgmr_data  out  8  write data.
- cpu_hold  out  1  high while the CPU must stay in reset; the top level ANDs `~cpu_hold` into `CPU_RESET`.
- done  out  1  level; image loaded successfully.
- error  out  3  0 none, 1 bad magic, 2 bad PRG size, 3 bad CHR size, 4 unsupported mapper.
- prg_banks  out  2  16 KB PRG bank count (1 or 2); the cartridge uses it to mirror NROM-128.
- mirroring  out  1  header flags6 bit 0.

## Operation
- States: HDR, TRAINER, PRG, CHR, DONE, ERR.
- A byte is accepted when `byte_valid & byte_ready`.
- `byte_ready = (state ∈ {HDR, TRAINER, PRG, CHR}) & ~restart`.
- HDR uses a 4-bit index. Each byte is processed on acceptance:
  - Index 0–3 must equal 4E 45 53 1A; otherwise go to ERR with error=1.
  - Index 4: PRG count must be 1 or 2; otherwise error=2.
  - Index 5: CHR count must be 0 or 1; otherwise error=3.
  - Index 6: latch `mirroring` and the trainer flag (bit 2); mapper low nibble = bits 7:4.
  - Index 7: mapper high nibble = bits 7:4; a nonzero full mapper gives error=4.
  - Index 8–15: ignored.
- After index 15 the next state is TRAINER if the trainer flag is set, else PRG.
- TRAINER: a 9-bit counter discards 512 bytes, then goes to PRG.
- PRG: a 15-bit offset counter runs from 0.
  - Each accepted byte produces a write, `prgmr_addr = {1'b0, offset}`.
  - After byte `prg_banks*16384 - 1`, go to CHR, or to DONE if the CHR count is 0.
- CHR: a 13-bit counter; each accepted byte is a `chr_wren` write. After 8192 bytes, go to DONE.
- DONE and ERR are sticky until `restart` or reset.
- `restart` has priority over everything, including a simultaneous byte acceptance; that byte is not consumed.
  - On `restart`: state=HDR, counters and `error` cleared, `done`=0, `cpu_hold`=1.
  - Latched header fields are overwritten as the new header arrives.

## Timing
- Reset values:
  - state=HDR, so `byte_ready`=1 once RESET_n is high.
  - `cpu_hold`=1.
  - `done`=0, `error`=0, `prgmr_wren`=0, `chr_wren`=0, `prgmr_addr`=0, `prgmr_data`=0, `prg_banks`=0, `mirroring`=0.
- Write latency: a byte accepted in cycle N appears with its strobe, addr and data registered in cycle N+1. The strobe is high for exactly one cycle.
- Throughput: one byte per cycle sustained; there is no internal back-pressure.
- `byte_valid` low stalls all counters.
- Error is registered in the cycle after the offending byte; `byte_ready` drops in that same cycle.
- `done` rises and `cpu_hold` falls in the cycle after the final write strobe.
- `cpu_hold` stays 1 in ERR.
- Async reset mid-load clears immediately. Any write strobe due in the next cycle is cancelled.

## Structure
- Shared package `nes_pkg` holds:
  - `loader_state_t` enum.
  - `loader_err_t` enum with the codes listed under `error`.
  - Constants INES_MAGIC, INES_HDR_LEN=16, TRAINER_LEN=512, PRG_BANK_BYTES=16384, CHR_BANK_BYTES=8192.
- Single module; no sub-module needed.

## Test plan
- Valid NROM-256 image (hdr 4E 45 53 1A 02 01 01 00, 32 KB PRG, 8 KB CHR), streamed back-to-back:
  - 32768 `prgmr_wren` pulses at addr 0x0000–0x7FFF with matching data.
  - 8192 `chr_wren` pulses.
  - `done`=1, `cpu_hold`=0, `prg_banks`=2, `mirroring`=1.
- NROM-128 with trainer (flags6=04, PRG=1, CHR=0):
  - The 512 trainer bytes produce no writes.
  - PRG writes cover 0x0000–0x3FFF only.
  - `done` is asserted after the last PRG byte.
- Byte 2 = 0x54: ERR with `error`=1 the cycle after, `byte_ready`=0, no write strobes, `cpu_hold`=1.
- flags6=0x10 (mapper 1): `error`=4 after byte 7. PRG count 3: `error`=2 after byte 4.
- `byte_valid` toggled randomly during PRG: write count and addresses are identical to the back-to-back case.
- `restart` asserted mid-PRG in the same cycle as `byte_valid`: that byte is not written. A full re-sent image then loads correctly from addr 0.
